conv_sequencer: RTL and testbench

- Multi-cycle controller that drives the shared ALU in convolution mode (alu_control = 4'b1111) over a block of input words.
- Loads one kernel word once, streams LEN input words from data memory through the ALU, and writes each result back to memory.
- Sits between the core's control unit (start/done) and the data-memory and ALU ports. While busy, it owns both.

---
 rtl/conv_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_conv_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_sequencer.sv
// Convolution-mode ALU sequencer: loads one kernel word, then streams len words through the ALU to memory.
// Optional accumulator and sum write-back enabled by defining CONV_SEQ_ACC_EN.
module conv_sequencer #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] ker_addr,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [31:0]       alu_in1,
    output logic [31:0]       alu_in2,
    output logic [3:0]        alu_control,
`ifdef CONV_SEQ_ACC_EN
    output logic [31:0]       acc_out,
`endif
    input  logic [31:0]       alu_result
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_K,
        S_WAIT_K,
        S_LOAD_X,
        S_WAIT_X,
        S_EXEC,
        S_WRITE,
`ifdef CONV_SEQ_ACC_EN
        S_ACC_WR,
`endif
        S_DONE
    } state_t;

    localparam logic [3:0] ALU_CONV = 4'b1111;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_kaddr;
    logic [ADDR_W-1:0] r_dst;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_i;
    logic [31:0]       r_kernel;
    logic [31:0]       r_alu1;
    logic [31:0]       r_alu2;
    logic [31:0]       r_res;
    logic              w_accept;
    logic              w_last;
`ifdef CONV_SEQ_ACC_EN
    logic [31:0]       r_acc;
`endif

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_i == r_len - LEN_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (len != '0) ? S_LOAD_K : S_DONE;
                end
            end
            S_LOAD_K: w_next = S_WAIT_K;
            S_WAIT_K: w_next = S_LOAD_X;
            S_LOAD_X: w_next = S_WAIT_X;
            S_WAIT_X: w_next = S_EXEC;
            S_EXEC:   w_next = S_WRITE;
            S_WRITE: begin
`ifdef CONV_SEQ_ACC_EN
                w_next = w_last ? S_ACC_WR : S_LOAD_X;
`else
                w_next = w_last ? S_DONE : S_LOAD_X;
`endif
            end
`ifdef CONV_SEQ_ACC_EN
            S_ACC_WR: w_next = S_DONE;
`endif
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (r_state != S_IDLE);
        done        = 1'b0;
        rd_en       = 1'b0;
        rd_addr     = '0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        alu_control = 4'b0000;
        unique case (r_state)
            S_LOAD_K: begin
                rd_en   = 1'b1;
                rd_addr = r_kaddr;
            end
            S_LOAD_X: begin
                rd_en   = 1'b1;
                rd_addr = r_src + ADDR_W'(r_i);
            end
            S_EXEC: alu_control = ALU_CONV;
            S_WRITE: begin
                wr_en   = 1'b1;
                wr_addr = r_dst + ADDR_W'(r_i);
                wr_data = r_res;
            end
`ifdef CONV_SEQ_ACC_EN
            S_ACC_WR: begin
                wr_en   = 1'b1;
                wr_addr = r_dst + ADDR_W'(r_len);
                wr_data = r_acc;
            end
`endif
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Operand registers double as the ALU ports so they hold outside EXEC
    assign alu_in1 = r_alu1;
    assign alu_in2 = r_alu2;
`ifdef CONV_SEQ_ACC_EN
    assign acc_out = r_acc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src    <= '0;
            r_kaddr  <= '0;
            r_dst    <= '0;
            r_len    <= '0;
            r_i      <= '0;
            r_kernel <= '0;
            r_alu1   <= '0;
            r_alu2   <= '0;
            r_res    <= '0;
`ifdef CONV_SEQ_ACC_EN
            r_acc    <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_src   <= src_base;
                r_kaddr <= ker_addr;
                r_dst   <= dst_base;
                r_len   <= len;
`ifdef CONV_SEQ_ACC_EN
                r_acc   <= '0;
`endif
            end
            unique case (r_state)
                S_WAIT_K: begin
                    r_kernel <= rd_data;
                    r_i      <= '0;
                end
                S_WAIT_X: begin
                    r_alu1 <= rd_data;
                    r_alu2 <= r_kernel;
                end
                S_EXEC: r_res <= alu_result;
                S_WRITE: begin
                    if (!w_last) begin
                        r_i <= r_i + LEN_W'(1);
                    end
`ifdef CONV_SEQ_ACC_EN
                    r_acc <= r_acc + r_res;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer: stub ALU, behavioural memory,
// sequential reference model of each job, directed plus randomized jobs.
module tb_conv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  src_base = '0;
    logic [7:0]  ker_addr = '0;
    logic [7:0]  dst_base = '0;
    logic [7:0]  len = '0;
    logic        busy, done, rd_en, wr_en;
    logic [7:0]  rd_addr, wr_addr;
    logic [31:0] rd_data = '0;
    logic [31:0] wr_data, alu_in1, alu_in2, alu_result;
    logic [3:0]  alu_control;
`ifdef CONV_SEQ_ACC_EN
    logic [31:0] acc_out;
    localparam int ACC = 1;
`else
    localparam int ACC = 0;
`endif

    conv_sequencer #(.ADDR_W(8), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .src_base(src_base), .ker_addr(ker_addr),
        .dst_base(dst_base), .len(len),
        .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_control(alu_control),
`ifdef CONV_SEQ_ACC_EN
        .acc_out(acc_out),
`endif
        .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    assign alu_result = (alu_control == 4'b1111) ? alu_in1 + alu_in2 : 32'h0;

    logic [31:0] mem [256];
    logic [31:0] exp_mem [256];
    logic [31:0] exp_acc;

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    int n_checks = 0;
    int n_errors = 0;
    int rd_cnt, wr_cnt, alu_cnt, bad_op, done_cnt, both_cnt;
    logic [7:0] rd_q[$];
    logic [7:0] wr_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_en) begin
                rd_cnt++;
                rd_q.push_back(rd_addr);
            end
            if (wr_en) begin
                wr_cnt++;
                wr_q.push_back(wr_addr);
            end
            if (rd_en && wr_en) both_cnt++;
            if (alu_control != 4'b0000) begin
                alu_cnt++;
                if (alu_control != 4'b1111) bad_op++;
            end
            if (done) done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        rd_cnt = 0; wr_cnt = 0; alu_cnt = 0; bad_op = 0;
        done_cnt = 0; both_cnt = 0;
        rd_q.delete();
        wr_q.delete();
    endtask

    // Reference: elements processed strictly in order, kernel read once first
    task automatic model_job(input logic [7:0] k, input logic [7:0] s,
                             input logic [7:0] d, input int l);
        logic [31:0] kv, r, acc;
        kv  = exp_mem[k];
        acc = 0;
        for (int i = 0; i < l; i++) begin
            r = exp_mem[8'(s + i)] + kv;
            exp_mem[8'(d + i)] = r;
            acc += r;
        end
        if (ACC == 1 && l > 0) exp_mem[8'(d + l)] = acc;
        exp_acc = acc;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_rden"}, 32'(rd_en), 0);
        chk({tag, "_wren"}, 32'(wr_en), 0);
        chk({tag, "_rdaddr"}, 32'(rd_addr), 0);
        chk({tag, "_wraddr"}, 32'(wr_addr), 0);
        chk({tag, "_wrdata"}, wr_data, 0);
        chk({tag, "_in1"}, alu_in1, 0);
        chk({tag, "_in2"}, alu_in2, 0);
        chk({tag, "_op"}, 32'(alu_control), 0);
    endtask

    task automatic run_job(input string tag, input logic [7:0] k,
                           input logic [7:0] s, input logic [7:0] d,
                           input int l, input bit pulses);
        int cnt, bad, exp_lat;
        bit seen;
        exp_mem = mem;
        model_job(k, s, d, l);
        clear_mon();
        exp_lat = (l == 0) ? 1 : 3 + 4 * l + ACC;
        @(posedge clk); #1;
        ker_addr = k; src_base = s; dst_base = d; len = 8'(l);
        start = 1'b1;
        cnt = 0;
        seen = 0;
        while (cnt < 300 && !seen) begin
            @(posedge clk); #1;
            cnt++;
            if (cnt == 1) start = 1'b0;
            if (pulses && cnt == 3) begin
                start = 1'b1;
                ker_addr = 8'($urandom); src_base = 8'($urandom);
                dst_base = 8'($urandom); len = 8'($urandom);
            end
            if (pulses && cnt == 4) start = 1'b0;
            if (done) seen = 1;
        end
        chk({tag, "_timeout"}, 32'(seen), 1);
        chk({tag, "_latency"}, cnt, exp_lat);
        if (pulses) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            chk({tag, "_start_in_done"}, 32'(busy), 0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_wr_cnt"}, wr_cnt, (l == 0) ? 0 : l + ACC);
        chk({tag, "_rd_cnt"}, rd_cnt, (l == 0) ? 0 : l + 1);
        chk({tag, "_alu_cnt"}, alu_cnt, l);
        chk({tag, "_bad_op"}, bad_op, 0);
        chk({tag, "_rd_wr_overlap"}, both_cnt, 0);
        bad = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== exp_mem[a]) bad++;
        chk({tag, "_mem"}, bad, 0);
`ifdef CONV_SEQ_ACC_EN
        chk({tag, "_acc"}, acc_out, exp_acc);
`endif
    endtask

    initial begin
        int cnt;
        for (int a = 0; a < 256; a++) mem[a] = $urandom;
        #1;
        check_idle_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // basic job
        mem[8'h10] = 5;
        mem[8'h20] = 1; mem[8'h21] = 2; mem[8'h22] = 3;
        run_job("basic", 8'h10, 8'h20, 8'h40, 3, 0);
        chk("basic_w0", mem[8'h40], 6);
        chk("basic_w1", mem[8'h41], 7);
        chk("basic_w2", mem[8'h42], 8);
`ifdef CONV_SEQ_ACC_EN
        chk("basic_accw", mem[8'h43], 21);
        chk("basic_acc", acc_out, 21);
`endif

        run_job("len0", 8'h10, 8'h20, 8'h40, 0, 0);

        run_job("wrap", 8'h33, 8'hFE, 8'hFF, 3, 0);
        chk("wrap_rd_n", rd_q.size(), 4);
        if (rd_q.size() == 4)
            chk("wrap_rd", {rd_q[1], rd_q[2], rd_q[3]}, 24'hFEFF00);
        if (wr_q.size() >= 3)
            chk("wrap_wr", {wr_q[0], wr_q[1], wr_q[2]}, 24'hFF0001);

        run_job("ignored", 8'h10, 8'h20, 8'h60, 4, 1);

        for (int j = 0; j < 8; j++)
            run_job("rand", 8'($urandom), 8'($urandom), 8'($urandom),
                    $urandom_range(1, 12), (j % 2) == 1);

        // reset in the second element's EXEC cycle
        mem[8'h10] = 5;
        mem[8'h20] = 1; mem[8'h21] = 2; mem[8'h22] = 3;
        mem[8'h40] = 32'hDEADBEEF;
        mem[8'h41] = 32'hDEADBEEF;
        clear_mon();
        @(posedge clk); #1;
        ker_addr = 8'h10; src_base = 8'h20; dst_base = 8'h40; len = 3;
        start = 1'b1;
        cnt = 0;
        while (cnt < 9) begin
            @(posedge clk); #1;
            cnt++;
            if (cnt == 1) start = 1'b0;
        end
        chk("rst_in_exec", 32'(alu_control), 32'hF);
        chk("rst_exec_in1", alu_in1, 2);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_w0", mem[8'h40], 6);
        chk("midrst_w1", mem[8'h41], 32'hDEADBEEF);
        chk("midrst_wr_cnt", wr_cnt, 1);
        chk("midrst_idle", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
